// File: rtl/lfsr_rand_gen.sv
// rtl/lfsr_rand_gen.sv - on-request LFSR random generator with rejection sampling and lockup recovery
module lfsr_rand_gen #(
    parameter int                WIDTH        = 6,
    parameter logic [WIDTH-1:0]  TAPS         = 6'b000011,
    parameter logic [WIDTH-1:0]  DEFAULT_SEED = 6'b000001,
    parameter int                STEPS        = 1,
    parameter longint unsigned   LIMIT        = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             req,
    input  logic             free_run,
    output logic [WIDTH-1:0] out,
    output logic             valid,
    output logic             busy,
    output logic             lockup_err
);

    localparam int CW = $clog2(STEPS + 1);
    localparam logic [WIDTH:0] LIMIT_W = (WIDTH + 1)'(LIMIT);
    localparam logic [CW-1:0] STEPS_W = CW'(STEPS);

    // Parameter sanity: a bad combination could make a draw never terminate.
    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("lfsr_rand_gen: WIDTH must be 2..32");
    end
    if (STEPS < 1) begin : g_bad_steps
        $error("lfsr_rand_gen: STEPS must be >= 1");
    end
    if (LIMIT < 2 || LIMIT > (64'd1 << WIDTH)) begin : g_bad_limit
        $error("lfsr_rand_gen: LIMIT must be 2..2^WIDTH");
    end
    if (TAPS == '0) begin : g_bad_taps
        $error("lfsr_rand_gen: TAPS must be nonzero");
    end
    if (DEFAULT_SEED == '0) begin : g_bad_seed
        $error("lfsr_rand_gen: DEFAULT_SEED must be nonzero");
    end
    if (longint'(DEFAULT_SEED) >= LIMIT) begin : g_bad_seed_limit
        $error("lfsr_rand_gen: DEFAULT_SEED must be below LIMIT");
    end

    typedef enum logic {IDLE, STEP} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] out_d;
    logic             valid_d;
    logic             lockup_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fb;
    logic [WIDTH-1:0] raw_next;
    logic             raw_zero;
    logic [WIDTH-1:0] nxt;
    logic             accept;
    logic             last_step;

    // One LFSR step from the current state, with all-zero replaced by the default seed.
    always_comb begin
        fb        = ^(state_q & TAPS);
        raw_next  = {fb, state_q[WIDTH-1:1]};
        raw_zero  = (raw_next == '0);
        nxt       = raw_zero ? DEFAULT_SEED : raw_next;
        accept    = ({1'b0, nxt} < LIMIT_W);
        last_step = (cnt_q <= CW'(1));
    end

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_q <= IDLE;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    // FSM next state: load aborts anything, a draw ends only on an accepted value.
    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE: begin
                if (!load && req) begin
                    fsm_d = STEP;
                end
            end
            STEP: begin
                if (load) begin
                    fsm_d = IDLE;
                end else if (last_step && accept) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    // FSM outputs: busy is simply "a draw is in flight".
    always_comb begin
        busy = (fsm_q == STEP);
    end

    // Datapath next values: LFSR state, step counter, result and sticky lockup flag.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        out_d    = out;
        valid_d  = 1'b0;
        lockup_d = lockup_err;
        if (load) begin
            state_d = (seed == '0) ? DEFAULT_SEED : seed;
            cnt_d   = '0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    if (req) begin
                        cnt_d = STEPS_W;
                    end else if (free_run) begin
                        state_d  = nxt;
                        lockup_d = lockup_err | raw_zero;
                    end
                end
                STEP: begin
                    state_d  = nxt;
                    lockup_d = lockup_err | raw_zero;
                    cnt_d    = (cnt_q == '0) ? '0 : cnt_q - CW'(1);
                    if (last_step && accept) begin
                        out_d   = nxt;
                        valid_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= DEFAULT_SEED;
            cnt_q      <= '0;
            out        <= '0;
            valid      <= 1'b0;
            lockup_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out        <= out_d;
            valid      <= valid_d;
            lockup_err <= lockup_d;
        end
    end

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb/tb_lfsr_rand_gen.sv - scoreboard bench for lfsr_rand_gen across several parameter sets
module tb_lfsr_rand_gen;

    localparam int N = 5;

    logic       clock = 1'b0;
    logic       rst      [N];
    logic       load_s   [N];
    logic [5:0] seed_s   [N];
    logic       req_s    [N];
    logic       free_s   [N];
    logic [5:0] out_o    [N];
    logic       valid_o  [N];
    logic       busy_o   [N];
    logic       lock_o   [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int       idx;
        logic [5:0] val;
        int       at;
    } exp_t;

    exp_t sb[$];
    logic prev_v [N];

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // d0 defaults, d1 STEPS=3, d2 LIMIT=10, d3 degenerate taps, d4 STEPS=4
    lfsr_rand_gen u0 (.clock(clock), .reset(rst[0]), .load(load_s[0]), .seed(seed_s[0]), .req(req_s[0]),
        .free_run(free_s[0]), .out(out_o[0]), .valid(valid_o[0]), .busy(busy_o[0]), .lockup_err(lock_o[0]));
    lfsr_rand_gen #(.STEPS(3)) u1 (.clock(clock), .reset(rst[1]), .load(load_s[1]), .seed(seed_s[1]), .req(req_s[1]),
        .free_run(free_s[1]), .out(out_o[1]), .valid(valid_o[1]), .busy(busy_o[1]), .lockup_err(lock_o[1]));
    lfsr_rand_gen #(.LIMIT(10)) u2 (.clock(clock), .reset(rst[2]), .load(load_s[2]), .seed(seed_s[2]), .req(req_s[2]),
        .free_run(free_s[2]), .out(out_o[2]), .valid(valid_o[2]), .busy(busy_o[2]), .lockup_err(lock_o[2]));
    lfsr_rand_gen #(.TAPS(6'b000010)) u3 (.clock(clock), .reset(rst[3]), .load(load_s[3]), .seed(seed_s[3]), .req(req_s[3]),
        .free_run(free_s[3]), .out(out_o[3]), .valid(valid_o[3]), .busy(busy_o[3]), .lockup_err(lock_o[3]));
    lfsr_rand_gen #(.STEPS(4)) u4 (.clock(clock), .reset(rst[4]), .load(load_s[4]), .seed(seed_s[4]), .req(req_s[4]),
        .free_run(free_s[4]), .out(out_o[4]), .valid(valid_o[4]), .busy(busy_o[4]), .lockup_err(lock_o[4]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every valid pulse must match the oldest expected result.
    always @(negedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (valid_o[i] === 1'b1) begin
                chk($sformatf("valid_not_back_to_back[%0d]", i), prev_v[i], 0);
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_valid[%0d]", i), 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("valid_instance", i, e.idx);
                    chk($sformatf("out[%0d]", i), out_o[i], e.val);
                    chk($sformatf("valid_cycle[%0d]", i), cyc, e.at);
                end
            end
            prev_v[i] = valid_o[i];
        end
    end

    // One draw: push the expectation, pulse req, then measure busy and wait for the result.
    task automatic draw(input int i, input logic [5:0] exp_out, input int lat, input string name);
        int n;
        exp_t e;
        @(negedge clock);
        req_s[i] = 1'b1;
        e.idx = i;
        e.val = exp_out;
        e.at  = cyc + 1 + lat;
        sb.push_back(e);
        @(negedge clock);
        req_s[i] = 1'b0;
        n = 0;
        while (busy_o[i] === 1'b1 && n < 100) begin
            n++;
            @(negedge clock);
        end
        chk({name, "_busy_cycles"}, n, lat);
        repeat (2) @(negedge clock);
        chk({name, "_drained"}, sb.size(), 0);
        sb.delete();
    endtask

    task automatic pulse_reset(input int i);
        @(negedge clock);
        rst[i] = 1'b1;
        @(negedge clock);
        rst[i] = 1'b0;
    endtask

    task automatic do_load(input int i, input logic [5:0] s);
        @(negedge clock);
        load_s[i] = 1'b1;
        seed_s[i] = s;
        @(negedge clock);
        load_s[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rst[i] = 1'b1; load_s[i] = 1'b0; seed_s[i] = '0;
            req_s[i] = 1'b0; free_s[i] = 1'b0; prev_v[i] = 1'b0;
        end
        repeat (2) @(negedge clock);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("reset_out[%0d]", i), out_o[i], 0);
            chk($sformatf("reset_valid[%0d]", i), valid_o[i], 0);
            chk($sformatf("reset_busy[%0d]", i), busy_o[i], 0);
            chk($sformatf("reset_lockup[%0d]", i), lock_o[i], 0);
        end
        for (int i = 0; i < N; i++) rst[i] = 1'b0;

        // Defaults: 1 -> 32 -> 16 -> 8 -> 4
        draw(0, 6'd32, 1, "d0_draw1");
        draw(0, 6'd16, 1, "d0_draw2");
        draw(0, 6'd8,  1, "d0_draw3");
        draw(0, 6'd4,  1, "d0_draw4");

        // STEPS=3: three shifts 32,16,8
        draw(1, 6'd8, 3, "steps3");

        // LIMIT=10: 32 and 16 rejected, 8 accepted
        draw(2, 6'd8, 3, "limit10");

        // Full period of free running returns to 1, so the next draw is 32
        pulse_reset(0);
        @(negedge clock);
        free_s[0] = 1'b1;
        repeat (63) @(negedge clock);
        free_s[0] = 1'b0;
        draw(0, 6'd32, 1, "period63");
        chk("free_run_no_lockup", lock_o[0], 0);

        // Five free-run steps 1->32->16->8->4->2, draw from 2 gives 33
        pulse_reset(0);
        @(negedge clock);
        free_s[0] = 1'b1;
        repeat (5) @(negedge clock);
        free_s[0] = 1'b0;
        draw(0, 6'd33, 1, "free5");

        // Loading zero substitutes the default seed without flagging lockup
        do_load(0, 6'd0);
        chk("load_zero_lockup", lock_o[0], 0);
        draw(0, 6'd32, 1, "load_zero");
        do_load(0, 6'd5);
        draw(0, 6'd34, 1, "load5");

        // Degenerate taps: next of 1 is 0, replaced by 1; lockup sticks until reset
        draw(3, 6'd1, 1, "lockup_draw");
        chk("lockup_set", lock_o[3], 1);
        draw(3, 6'd1, 1, "lockup_draw2");
        chk("lockup_sticky", lock_o[3], 1);
        pulse_reset(3);
        chk("lockup_cleared", lock_o[3], 0);

        // STEPS=4: load mid-draw aborts with no valid
        draw(4, 6'd4, 4, "steps4_first");
        @(negedge clock);
        req_s[4] = 1'b1;
        @(negedge clock);
        req_s[4] = 1'b0;
        @(negedge clock);
        load_s[4] = 1'b1;
        seed_s[4] = 6'd5;
        @(negedge clock);
        load_s[4] = 1'b0;
        chk("abort_busy", busy_o[4], 0);
        chk("abort_out_held", out_o[4], 4);
        repeat (6) @(negedge clock);
        // From 5: 34, 49, 56, 28
        draw(4, 6'd28, 4, "after_abort");

        // Reset mid-draw returns everything to reset values, state 1
        @(negedge clock);
        req_s[4] = 1'b1;
        @(negedge clock);
        req_s[4] = 1'b0;
        @(negedge clock);
        rst[4] = 1'b1;
        #1;
        chk("mid_reset_out", out_o[4], 0);
        chk("mid_reset_busy", busy_o[4], 0);
        chk("mid_reset_valid", valid_o[4], 0);
        @(negedge clock);
        rst[4] = 1'b0;
        repeat (6) @(negedge clock);
        draw(4, 6'd4, 4, "after_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
